lsq_ring: RTL and testbench
===========================

Name: lsq_ring

Overview:
- Parametrised in-order load/store queue: the next generation of the core's load/store buffer.
- Sits between issue (enqueue), the ROB (store commit, result writeback) and the memory allocator (request/grant/done).
- Generalised vs. previous generation: configurable depth, configurable number of result-broadcast channels, byte/half/word sizes with sign control.
- Adds an explicit head FSM with latched request state, so a committed store survives a branch flush.

Parameters:
- DEPTH, 16, queue entries; power of two, at least 2.
- IDX_W, 4, log2(DEPTH).
- TAG_W, 4, ROB tag width; tag 0 means operand ready.
- XLEN, 32, data/address width.
- NUM_CDB, 2, number of result broadcast channels snooped.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; when low all state holds
- clear_in  in  1  branch-mispredict flush
- enq_en_in  in  1  enqueue one entry
- enq_is_store_in  in  1  1=store, 0=load
- enq_size_in  in  2  0=byte, 1=half, 2=word
- enq_signed_in  in  1  load sign-extends
- enq_rob_in  in  TAG_W  ROB tag of the instruction
- enq_imm_in  in  XLEN  address offset
- enq_q1_in/enq_q2_in  in  TAG_W  base/data source tags
- enq_v1_in/enq_v2_in  in  XLEN  base/data values (valid when tag=0)
- full_out, empty_out  out  1  queue status (combinational from count)
- count_out  out  IDX_W+1  occupied entries
- cdb_en_in  in  NUM_CDB  broadcast valid per channel
- cdb_tag_in  in  NUM_CDB*TAG_W  packed tags
- cdb_data_in  in  NUM_CDB*XLEN  packed data
- commit_req_out  out  1  head store ready, awaiting commit
- commit_rob_out  out  TAG_W  tag of that store
- commit_in  in  1  ROB permits head store to proceed
- mem_req_out  out  1  memory request
- mem_we_out  out  1  write
- mem_addr_out  out  XLEN  byte address
- mem_size_out  out  2  as enq_size_in
- mem_wdata_out  out  XLEN  store data
- mem_gnt_in  in  1  request accepted
- mem_done_in  in  1  access complete
- mem_rdata_in  in  XLEN  load data (low bytes valid)
- res_en_out  out  1  load result valid, 1-cycle pulse
- res_rob_out  out  TAG_W  load tag
- res_data_out  out  XLEN  extended load result

Behaviour:
- Reset:
  - head=tail=count=0; FSM=IDLE.
  - All outputs 0; empty_out=1.
- Enqueue:
  - Write at tail when enq_en_in && !full_out; enqueue while full is ignored.
  - Operands matching a same-cycle CDB tag (any channel, tag≠0) capture that data and store tag 0.
- Snoop: every valid entry with q≠0 equal to any valid cdb tag takes the data and sets q=0. Lowest channel index wins on duplicate tags.
- Pointers: head/tail wrap modulo DEPTH. Simultaneous enqueue and pop leaves count unchanged.
- Address: v1+imm, truncated to XLEN.
- Store data: v2; bytes above the access size are don't-care.
- Head FSM: IDLE, WAIT_COMMIT, REQ, WAIT_DATA.
  - IDLE, head valid, q1=q2=0, load: latch addr/size/tag into FSM registers, pop the entry, go to REQ.
  - IDLE, head valid, q1=q2=0, store: drive commit_req_out=1 and commit_rob_out, go to WAIT_COMMIT.
  - WAIT_COMMIT, on commit_in: latch addr/data/size, pop, drop commit_req_out, go to REQ.
  - REQ: mem_req_out held high with stable fields until mem_gnt_in, then go to WAIT_DATA. mem_gnt_in in the same cycle as REQ entry is not sampled.
  - WAIT_DATA, on mem_done_in:
    - Load: res_en_out=1 for one cycle with data zero/sign-extended per size/signed.
    - Return to IDLE.
  - Minimum load latency: operands ready to mem_req_out is 1 cycle.
- clear_in (overrides a same-cycle enqueue):
  - Queue emptied: head=tail=count=0.
  - WAIT_COMMIT goes to IDLE.
  - Store in REQ/WAIT_DATA continues to completion (already committed).
  - Load in REQ is dropped to IDLE.
  - Load in WAIT_DATA waits for mem_done_in with res_en_out suppressed.
- rst_in during any state forces the reset values immediately.

Optional Feature:
- Macro LSQ_MMIO_EN.
- When defined: a load with addr[17:16]==2'b11 is treated as I/O.
  - It follows the store path: commit_req_out, then commit_in.
  - It must never execute speculatively.
  - After commit it issues as a normal read and produces res_en_out.
- When undefined: all loads issue as soon as operands are ready; no address decoding.

Test Plan:
- Reset, then enqueue load LW, v1=0x100, imm=4, tags 0; gnt next cycle, done with 0xDEADBEEF → mem_addr_out=0x104, res_en_out pulse with 0xDEADBEEF.
- LB signed, rdata=0x00000080 → res_data_out=0xFFFFFF80. LBU with the same data → 0x00000080.
- Store SW with q1=3; cdb channel 1 broadcasts tag 3 data 0x200 → commit_req_out high, commit_rob_out correct. commit_in → write at 0x200+imm, mem_we_out=1.
- Fill DEPTH entries → full_out=1, extra enqueue ignored, count_out=DEPTH. Drain all with head wrap → empty_out=1.
- Committed store granted, clear_in asserted → store completes on mem_done_in; queue empty; no res_en_out.
- LSQ_MMIO_EN: load from 0x30000 → no mem_req_out until commit_in. Undefined: request issues immediately.

Source files
------------

// File: rtl/lsq_ring.sv
`default_nettype none
// ============================================================================
// Module   : lsq_ring
// Brief    : In-order load/store queue with CDB snooping and a head FSM that
//            latches the outstanding memory request. Optional macro
//            LSQ_MMIO_EN routes loads to addr[17:16]==2'b11 through commit.
// Revision : 1.0
// ============================================================================
module lsq_ring #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     enq_en_in,
    input  logic                     enq_is_store_in,
    input  logic [1:0]               enq_size_in,
    input  logic                     enq_signed_in,
    input  logic [TAG_W-1:0]         enq_rob_in,
    input  logic [XLEN-1:0]          enq_imm_in,
    input  logic [TAG_W-1:0]         enq_q1_in,
    input  logic [TAG_W-1:0]         enq_q2_in,
    input  logic [XLEN-1:0]          enq_v1_in,
    input  logic [XLEN-1:0]          enq_v2_in,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [IDX_W:0]           count_out,
    input  logic [NUM_CDB-1:0]       cdb_en_in,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_in,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data_in,
    output logic                     commit_req_out,
    output logic [TAG_W-1:0]         commit_rob_out,
    input  logic                     commit_in,
    output logic                     mem_req_out,
    output logic                     mem_we_out,
    output logic [XLEN-1:0]          mem_addr_out,
    output logic [1:0]               mem_size_out,
    output logic [XLEN-1:0]          mem_wdata_out,
    input  logic                     mem_gnt_in,
    input  logic                     mem_done_in,
    input  logic [XLEN-1:0]          mem_rdata_in,
    output logic                     res_en_out,
    output logic [TAG_W-1:0]         res_rob_out,
    output logic [XLEN-1:0]          res_data_out
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_WAIT_COMMIT = 2'd1;
    localparam logic [1:0] S_REQ         = 2'd2;
    localparam logic [1:0] S_WAIT_DATA   = 2'd3;
    localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] e_store;
    logic [DEPTH-1:0] e_signed;
    logic [1:0]       e_size [DEPTH];
    logic [TAG_W-1:0] e_rob  [DEPTH];
    logic [TAG_W-1:0] e_q1   [DEPTH];
    logic [TAG_W-1:0] e_q2   [DEPTH];
    logic [XLEN-1:0]  e_imm  [DEPTH];
    logic [XLEN-1:0]  e_v1   [DEPTH];
    logic [XLEN-1:0]  e_v2   [DEPTH];
    logic [XLEN:0]    snp1   [DEPTH];
    logic [XLEN:0]    snp2   [DEPTH];
    logic [XLEN:0]    enq_s1;
    logic [XLEN:0]    enq_s2;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;
    logic [1:0]       state;
    logic [1:0]       state_nx;

    logic [XLEN-1:0]  f_addr;
    logic [XLEN-1:0]  f_wdata;
    logic [1:0]       f_size;
    logic [TAG_W-1:0] f_rob;
    logic             f_signed;
    logic             f_we;
    logic             f_commit;
    logic             f_kill;

    logic [XLEN-1:0]  head_addr;
    logic             head_ready;
    logic             head_commit_path;
    logic             do_enq;
    logic             pop;
    logic [XLEN-1:0]  ext_data;

    // Returns {hit, data}; scanning high to low lets the lowest channel win.
    function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] q,
                                            input logic [XLEN-1:0]  v);
        logic [XLEN:0] r;
        r = {1'b0, v};
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_en_in[c] && (q != '0) && (cdb_tag_in[c*TAG_W +: TAG_W] == q))
                r = {1'b1, cdb_data_in[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snp1[i] = snoop(e_q1[i], e_v1[i]);
            snp2[i] = snoop(e_q2[i], e_v2[i]);
        end
        enq_s1 = snoop(enq_q1_in, enq_v1_in);
        enq_s2 = snoop(enq_q2_in, enq_v2_in);
    end

    assign full_out   = (count == FULL_CNT);
    assign empty_out  = (count == '0);
    assign count_out  = count;

    assign head_addr  = e_v1[head] + e_imm[head];
    assign head_ready = !empty_out && (e_q1[head] == '0) && (e_q2[head] == '0);
`ifdef LSQ_MMIO_EN
    assign head_commit_path = e_store[head] || (head_addr[17:16] == 2'b11);
`else
    assign head_commit_path = e_store[head];
`endif

    assign do_enq = rdy_in && !clear_in && enq_en_in && !full_out;
    assign pop    = rdy_in && !clear_in &&
                    (((state == S_IDLE) && head_ready && !head_commit_path) ||
                     ((state == S_WAIT_COMMIT) && commit_in));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_enq) tail <= tail + IDX_W'(1);
                if (pop)    head <= head + IDX_W'(1);
                case ({do_enq, pop})
                    2'b10:   count <= count + (IDX_W+1)'(1);
                    2'b01:   count <= count - (IDX_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Snoop every slot each cycle; a same-cycle enqueue at tail overrides.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            e_store  <= '0;
            e_signed <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_size[i] <= '0;
                e_rob[i]  <= '0;
                e_q1[i]   <= '0;
                e_q2[i]   <= '0;
                e_imm[i]  <= '0;
                e_v1[i]   <= '0;
                e_v2[i]   <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (snp1[i][XLEN]) begin
                    e_q1[i] <= '0;
                    e_v1[i] <= snp1[i][XLEN-1:0];
                end
                if (snp2[i][XLEN]) begin
                    e_q2[i] <= '0;
                    e_v2[i] <= snp2[i][XLEN-1:0];
                end
            end
            if (do_enq) begin
                e_store[tail]  <= enq_is_store_in;
                e_signed[tail] <= enq_signed_in;
                e_size[tail]   <= enq_size_in;
                e_rob[tail]    <= enq_rob_in;
                e_imm[tail]    <= enq_imm_in;
                e_q1[tail]     <= enq_s1[XLEN] ? '0 : enq_q1_in;
                e_q2[tail]     <= enq_s2[XLEN] ? '0 : enq_q2_in;
                e_v1[tail]     <= enq_s1[XLEN-1:0];
                e_v2[tail]     <= enq_s2[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state <= S_IDLE;
        else if (rdy_in)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:
                if (!clear_in && head_ready)
                    state_nx = head_commit_path ? S_WAIT_COMMIT : S_REQ;
            S_WAIT_COMMIT:
                if (clear_in)
                    state_nx = S_IDLE;
                else if (commit_in)
                    state_nx = S_REQ;
            S_REQ:
                if (clear_in && !f_commit)
                    state_nx = S_IDLE;
                else if (mem_gnt_in)
                    state_nx = S_WAIT_DATA;
            S_WAIT_DATA:
                if (mem_done_in)
                    state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    // Request fields are frozen at pop so a flush cannot disturb them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            f_addr   <= '0;
            f_wdata  <= '0;
            f_size   <= '0;
            f_rob    <= '0;
            f_signed <= 1'b0;
            f_we     <= 1'b0;
            f_commit <= 1'b0;
            f_kill   <= 1'b0;
        end else if (pop) begin
            f_addr   <= head_addr;
            f_wdata  <= e_v2[head];
            f_size   <= e_size[head];
            f_rob    <= e_rob[head];
            f_signed <= e_signed[head];
            f_we     <= e_store[head];
            f_commit <= (state == S_WAIT_COMMIT);
            f_kill   <= 1'b0;
        end else if (rdy_in && clear_in && (state == S_WAIT_DATA) && !f_commit) begin
            f_kill   <= 1'b1;
        end
    end

    always_comb begin
        case (f_size)
            2'd0:    ext_data = {{(XLEN-8){f_signed & mem_rdata_in[7]}}, mem_rdata_in[7:0]};
            2'd1:    ext_data = {{(XLEN-16){f_signed & mem_rdata_in[15]}}, mem_rdata_in[15:0]};
            default: ext_data = mem_rdata_in;
        endcase
    end

    always_comb begin
        commit_req_out = (state == S_WAIT_COMMIT);
        commit_rob_out = commit_req_out ? e_rob[head] : '0;
        mem_req_out    = (state == S_REQ);
        mem_we_out     = mem_req_out && f_we;
        mem_addr_out   = mem_req_out ? f_addr  : '0;
        mem_size_out   = mem_req_out ? f_size  : '0;
        mem_wdata_out  = mem_req_out ? f_wdata : '0;
        res_en_out     = rdy_in && (state == S_WAIT_DATA) && mem_done_in &&
                         !f_we && !f_kill && !clear_in;
        res_rob_out    = res_en_out ? f_rob    : '0;
        res_data_out   = res_en_out ? ext_data : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsq_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_ring
// Brief    : Directed self-checking bench for lsq_ring.
// Revision : 1.0
// ============================================================================
module tb_lsq_ring;

    localparam int DEPTH   = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 4;
    localparam int XLEN    = 32;
    localparam int NUM_CDB = 2;

    logic                     clk_in = 1'b0;
    logic                     rst_in, rdy_in, clear_in;
    logic                     enq_en_in, enq_is_store_in, enq_signed_in;
    logic [1:0]               enq_size_in;
    logic [TAG_W-1:0]         enq_rob_in, enq_q1_in, enq_q2_in;
    logic [XLEN-1:0]          enq_imm_in, enq_v1_in, enq_v2_in;
    logic                     full_out, empty_out;
    logic [IDX_W:0]           count_out;
    logic [NUM_CDB-1:0]       cdb_en_in;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag_in;
    logic [NUM_CDB*XLEN-1:0]  cdb_data_in;
    logic                     commit_req_out, commit_in;
    logic [TAG_W-1:0]         commit_rob_out;
    logic                     mem_req_out, mem_we_out, mem_gnt_in, mem_done_in;
    logic [XLEN-1:0]          mem_addr_out, mem_wdata_out, mem_rdata_in;
    logic [1:0]               mem_size_out;
    logic                     res_en_out;
    logic [TAG_W-1:0]         res_rob_out;
    logic [XLEN-1:0]          res_data_out;

    int errors = 0;
    int checks = 0;

    lsq_ring #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .enq_en_in(enq_en_in), .enq_is_store_in(enq_is_store_in), .enq_size_in(enq_size_in),
        .enq_signed_in(enq_signed_in), .enq_rob_in(enq_rob_in), .enq_imm_in(enq_imm_in),
        .enq_q1_in(enq_q1_in), .enq_q2_in(enq_q2_in), .enq_v1_in(enq_v1_in), .enq_v2_in(enq_v2_in),
        .full_out(full_out), .empty_out(empty_out), .count_out(count_out),
        .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .commit_req_out(commit_req_out), .commit_rob_out(commit_rob_out), .commit_in(commit_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
        .mem_size_out(mem_size_out), .mem_wdata_out(mem_wdata_out), .mem_gnt_in(mem_gnt_in),
        .mem_done_in(mem_done_in), .mem_rdata_in(mem_rdata_in),
        .res_en_out(res_en_out), .res_rob_out(res_rob_out), .res_data_out(res_data_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enq(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [TAG_W-1:0] rob, input logic [TAG_W-1:0] q1,
                       input logic [TAG_W-1:0] q2, input logic [XLEN-1:0] v1,
                       input logic [XLEN-1:0] v2, input logic [XLEN-1:0] imm);
        enq_en_in = 1'b1; enq_is_store_in = st; enq_size_in = sz; enq_signed_in = sg;
        enq_rob_in = rob; enq_q1_in = q1; enq_q2_in = q2;
        enq_v1_in = v1; enq_v2_in = v2; enq_imm_in = imm;
        tick();
        enq_en_in = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [XLEN-1:0] exp_addr,
                            input logic [TAG_W-1:0] rob, input logic [XLEN-1:0] rdata,
                            input logic [XLEN-1:0] exp_data);
        for (int k = 0; k < 8 && !mem_req_out; k++) tick();
        chk({tag, "_req"}, mem_req_out, 1);
        chk({tag, "_addr"}, mem_addr_out, exp_addr);
        chk({tag, "_we"}, mem_we_out, 0);
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        mem_done_in = 1'b1;
        mem_rdata_in = rdata;
        #1;
        chk({tag, "_res_en"}, res_en_out, 1);
        chk({tag, "_res_rob"}, res_rob_out, rob);
        chk({tag, "_res_data"}, res_data_out, exp_data);
        tick();
        mem_done_in = 1'b0;
        chk({tag, "_res_pulse"}, res_en_out, 0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
        enq_en_in = 1'b0; enq_is_store_in = 1'b0; enq_signed_in = 1'b0; enq_size_in = '0;
        enq_rob_in = '0; enq_q1_in = '0; enq_q2_in = '0;
        enq_imm_in = '0; enq_v1_in = '0; enq_v2_in = '0;
        cdb_en_in = '0; cdb_tag_in = '0; cdb_data_in = '0;
        commit_in = 1'b0; mem_gnt_in = 1'b0; mem_done_in = 1'b0; mem_rdata_in = '0;

        repeat (2) tick();
        chk("rst_empty", empty_out, 1);
        chk("rst_full", full_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_mem_req", mem_req_out, 0);
        chk("rst_commit_req", commit_req_out, 0);
        chk("rst_res_en", res_en_out, 0);
        rst_in = 1'b0;
        tick();

        // LW: entry visible, request exactly one cycle later
        enq(0, 2'd2, 0, 4'd1, 0, 0, 32'h100, 0, 32'h4);
        chk("lw_count", count_out, 1);
        chk("lw_lat0", mem_req_out, 0);
        tick();
        chk("lw_lat1", mem_req_out, 1);
        run_load("lw", 32'h104, 4'd1, 32'hDEADBEEF, 32'hDEADBEEF);

        enq(0, 2'd0, 1, 4'd2, 0, 0, 32'h10, 0, 32'h1);
        run_load("lb", 32'h11, 4'd2, 32'h00000080, 32'hFFFFFF80);
        enq(0, 2'd0, 0, 4'd3, 0, 0, 32'h10, 0, 32'h1);
        run_load("lbu", 32'h11, 4'd3, 32'h00000080, 32'h00000080);
        enq(0, 2'd1, 1, 4'd4, 0, 0, 32'h20, 0, 32'h2);
        run_load("lh", 32'h22, 4'd4, 32'h12348001, 32'hFFFF8001);

        // Enqueue-time capture, both channels carry tag 4: channel 0 wins
        cdb_en_in = 2'b11; cdb_tag_in = {4'd4, 4'd4}; cdb_data_in = {32'h400, 32'h300};
        enq(0, 2'd2, 0, 4'd5, 4'd4, 0, 0, 0, 32'h10);
        cdb_en_in = '0;
        run_load("cap", 32'h310, 4'd5, 32'h1111, 32'h1111);

        // Store waiting on q1=3, resolved by channel 1
        enq(1, 2'd2, 0, 4'd6, 4'd3, 0, 0, 32'h55AA, 32'h8);
        chk("st_noreq0", commit_req_out, 0);
        cdb_en_in = 2'b11; cdb_tag_in = {4'd3, 4'd5}; cdb_data_in = {32'h200, 32'h999};
        tick();
        cdb_en_in = '0;
        chk("st_noreq1", commit_req_out, 0);
        tick();
        chk("st_commit_req", commit_req_out, 1);
        chk("st_commit_rob", commit_rob_out, 6);
        chk("st_no_mem", mem_req_out, 0);
        tick();
        chk("st_commit_hold", commit_req_out, 1);
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
        chk("st_commit_drop", commit_req_out, 0);
        chk("st_req", mem_req_out, 1);
        chk("st_we", mem_we_out, 1);
        chk("st_addr", mem_addr_out, 32'h208);
        chk("st_wdata", mem_wdata_out, 32'h55AA);
        chk("st_size", mem_size_out, 2);
        chk("st_count", count_out, 0);
        tick();
        chk("st_req_hold", mem_req_out, 1);
        chk("st_addr_hold", mem_addr_out, 32'h208);
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        chk("st_req_off", mem_req_out, 0);
        mem_done_in = 1'b1;
        #1;
        chk("st_no_res", res_en_out, 0);
        tick();
        mem_done_in = 1'b0;

        // Fill with stores (head stalls in WAIT_COMMIT), then drain across the wrap
        for (int i = 0; i < DEPTH; i++)
            enq(1, 2'd2, 0, TAG_W'(i), 0, 0, XLEN'(i * 4), XLEN'(i), 0);
        chk("fill_full", full_out, 1);
        chk("fill_count", count_out, DEPTH);
        enq(1, 2'd2, 0, 4'd9, 0, 0, 32'h999, 0, 0);
        chk("over_count", count_out, DEPTH);
        chk("over_full", full_out, 1);
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 8 && !commit_req_out; k++) tick();
            chk("drain_rob", commit_rob_out, XLEN'(i));
            commit_in = 1'b1;
            tick();
            commit_in = 1'b0;
            chk("drain_addr", mem_addr_out, XLEN'(i * 4));
            mem_gnt_in = 1'b1;
            tick();
            mem_gnt_in = 1'b0;
            mem_done_in = 1'b1;
            tick();
            mem_done_in = 1'b0;
        end
        chk("drain_empty", empty_out, 1);
        chk("drain_count", count_out, 0);
        repeat (2) tick();
        chk("drain_no_extra", commit_req_out, 0);

        // Flush while a committed store is in flight; flush beats enqueue
        enq(1, 2'd2, 0, 4'd7, 0, 0, 32'h40, 32'h11, 0);
        enq(0, 2'd2, 0, 4'd8, 0, 0, 32'h80, 0, 0);
        for (int k = 0; k < 8 && !commit_req_out; k++) tick();
        chk("clr_commit_rob", commit_rob_out, 7);
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
        chk("clr_st_addr", mem_addr_out, 32'h40);
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        clear_in = 1'b1;
        enq_en_in = 1'b1; enq_is_store_in = 1'b0; enq_rob_in = 4'd9; enq_q1_in = '0; enq_q2_in = '0;
        tick();
        clear_in = 1'b0;
        enq_en_in = 1'b0;
        chk("clr_count", count_out, 0);
        chk("clr_empty", empty_out, 1);
        mem_done_in = 1'b1;
        #1;
        chk("clr_st_no_res", res_en_out, 0);
        tick();
        mem_done_in = 1'b0;
        repeat (3) tick();
        chk("clr_no_req", mem_req_out, 0);
        chk("clr_no_commit", commit_req_out, 0);

        // Load in REQ is dropped by a flush
        enq(0, 2'd2, 0, 4'd10, 0, 0, 32'h50, 0, 0);
        tick();
        chk("ldreq_req", mem_req_out, 1);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("ldreq_dropped", mem_req_out, 0);
        tick();
        chk("ldreq_stays", mem_req_out, 0);

        // Load in WAIT_DATA completes silently after a flush
        enq(0, 2'd2, 0, 4'd11, 0, 0, 32'h60, 0, 0);
        tick();
        mem_gnt_in = 1'b1;
        tick();
        mem_gnt_in = 1'b0;
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        mem_done_in = 1'b1; mem_rdata_in = 32'hCAFE;
        #1;
        chk("ldwd_no_res", res_en_out, 0);
        tick();
        mem_done_in = 1'b0;
        chk("ldwd_idle", mem_req_out, 0);

        // rdy_in low freezes the queue
        rdy_in = 1'b0;
        enq_en_in = 1'b1; enq_is_store_in = 1'b0; enq_q1_in = '0; enq_q2_in = '0;
        repeat (2) tick();
        chk("rdy_hold_count", count_out, 0);
        enq_en_in = 1'b0;
        rdy_in = 1'b1;

        // Load from the I/O window 0x30000
        enq(0, 2'd2, 0, 4'd12, 0, 0, 32'h30000, 0, 0);
        tick();
`ifdef LSQ_MMIO_EN
        chk("mmio_commit_req", commit_req_out, 1);
        chk("mmio_no_spec", mem_req_out, 0);
        tick();
        chk("mmio_still_no_req", mem_req_out, 0);
        commit_in = 1'b1;
        tick();
        commit_in = 1'b0;
`else
        chk("mmio_no_commit", commit_req_out, 0);
        chk("mmio_immediate", mem_req_out, 1);
`endif
        run_load("mmio", 32'h30000, 4'd12, 32'hAB, 32'hAB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
